// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// FSM state codes match the legacy encoding: idle=0, run=1, done=2.
package serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/one_bit_adder.sv
// Existing one-bit full-adder cell, time-shared by serial_adder_ctrl.
module one_bit_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller around one one_bit_adder cell, LSB first.
// Define SERIAL_SUB_EN to add the sub port (A-B via inverted B and carry-in of 1).
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             cell_s, cell_cout;
   logic             sub_op;

`ifdef SERIAL_SUB_EN
   assign sub_op = sub;
`else
   assign sub_op = 1'b0;
`endif

   one_bit_adder u_cell (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .s    (cell_s),
      .cout (cell_cout)
   );

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;
      ready    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         StIdle: begin
            ready = 1'b1;
            if (start) begin
               a_sh_d  = a;
               // Subtraction is A + ~B + 1: invert B and seed the carry.
               b_sh_d  = sub_op ? ~b : b;
               carry_d = sub_op;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            busy     = 1'b1;
            sum_sh_d = {cell_s, sum_sh_q[WIDTH-1:1]};
            carry_d  = cell_cout;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            if (cnt_q == LastCnt) begin
               sum_d   = {cell_s, sum_sh_q[WIDTH-1:1]};
               cout_d  = cell_cout;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized bench for serial_adder_ctrl (WIDTH=8), checked against
// an arithmetic model; sub tests run only when SERIAL_SUB_EN is defined.
module tb_serial_adder_ctrl;

   localparam int W = 8;
   localparam int NumB2b = 20;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         ready, busy, done, cout;
   logic [W-1:0] sum;

   int n_checks = 0;
   int n_errors = 0;
   logic [W-1:0] last_sum = '0;
   logic         last_cout = 1'b0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_SUB_EN
      .sub   (sub),
`endif
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   // Reference: {cout, sum}; subtraction carry means "no borrow", i.e. x >= y.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic s);
      if (s) return {(x >= y), W'(x - y)};
      return (W+1)'(x) + (W+1)'(y);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full operation with cycle-accurate checks; starts and ends on a negedge.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                        input string tag);
      logic [W:0] exp;
      int bad;
      exp = model(ta, tb_, ts);
      check({tag, "_ready"}, 32'(ready), 32'd1);
      a = ta; b = tb_; sub = ts; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      bad = 0;
      for (int i = 0; i < W; i++) begin
         if (busy !== 1'b1 || done !== 1'b0 || ready !== 1'b0 ||
             sum !== last_sum || cout !== last_cout) bad++;
         a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
         @(negedge clk);
      end
      check({tag, "_run_window"}, 32'(bad), 32'd0);
      check({tag, "_done"}, 32'({done, busy, ready}), 32'b100);
      check({tag, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
      check({tag, "_cout"}, 32'(cout), 32'(exp[W]));
      last_sum = exp[W-1:0];
      last_cout = exp[W];
      @(negedge clk);
      check({tag, "_after"}, 32'({done, busy, ready}), 32'b001);
   endtask

   // Waits on negedges for a done pulse; returns cycles waited or -1 on timeout.
   task automatic wait_done(input int limit, output int cycles);
      cycles = -1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            cycles = i;
            break;
         end
      end
   endtask

   initial begin
      int cyc, last_done, ndone, cycles, bad;
      logic [2*W:0] q[$];
      logic [2*W:0] ent;
      logic [W:0] exp;

      // Reset state
      #1;
      check("rst_outputs", 32'({ready, busy, done}), 32'b100);
      check("rst_sum", 32'({cout, sum}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(8'h3C, 8'h05, 1'b0, "add_3c_05");
      do_op(8'hFF, 8'h01, 1'b0, "carry_ff_01");

      // start held through RUN with new operands: ignored, then relaunches from IDLE
      a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a = 8'h11; b = 8'h22;
      wait_done(W + 4, cycles);
      check("held_first_latency", 32'(cycles), 32'(W));
      check("held_first_sum", 32'({cout, sum}), 32'h046);
      @(negedge clk);
      check("held_idle_ready", 32'(ready), 32'd1);
      wait_done(W + 4, cycles);
      start = 1'b0;
      check("held_second_latency", 32'(cycles), 32'(W + 1));
      check("held_second_sum", 32'({cout, sum}), 32'h033);
      last_sum = 8'h33; last_cout = 1'b0;
      @(negedge clk);

`ifdef SERIAL_SUB_EN
      do_op(8'h05, 8'h07, 1'b1, "sub_05_07");
      do_op(8'h07, 8'h05, 1'b1, "sub_07_05");
      do_op(8'h5A, 8'h5A, 1'b1, "sub_equal");
`endif
      do_op(8'h80, 8'h80, 1'b0, "add_80_80");

      // Back-to-back with random operands; start held continuously
      a = W'($urandom); b = W'($urandom);
`ifdef SERIAL_SUB_EN
      sub = 1'($urandom);
`else
      sub = 1'b0;
`endif
      start = 1'b1;
      cyc = 0; last_done = -1; ndone = 0;
      while (ndone < NumB2b && cyc < NumB2b * (W + 2) + 20) begin
         if (done === 1'b1) begin
            if (q.size() > 0) begin
               ent = q.pop_front();
               exp = model(ent[2*W-1:W], ent[W-1:0], ent[2*W]);
               check("b2b_result", 32'({cout, sum}), 32'(exp));
            end else begin
               check("b2b_spurious_done", 32'd1, 32'(q.size()));
            end
            if (last_done >= 0) check("b2b_spacing", 32'(cyc - last_done), 32'(W + 2));
            last_done = cyc;
            ndone++;
         end
         if (ready === 1'b1) begin
            q.push_back({sub, a, b});
         end else begin
            a = W'($urandom); b = W'($urandom);
`ifdef SERIAL_SUB_EN
            sub = 1'($urandom);
`endif
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      sub = 1'b0;
      check("b2b_count", 32'(ndone), 32'(NumB2b));
      last_sum = sum; last_cout = cout;
      repeat (2) @(negedge clk);

      // Reset asserted during the 4th RUN cycle of AA+55
      do_op(8'h0F, 8'h0F, 1'b0, "pre_abort");
      a = 8'hAA; b = 8'h55; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_outputs", 32'({ready, busy, done}), 32'b100);
      check("abort_sum", 32'({cout, sum}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 2 * W; i++) begin
         @(negedge clk);
         if (done !== 1'b0 || ready !== 1'b1) bad++;
      end
      check("abort_no_done", 32'(bad), 32'd0);
      last_sum = '0; last_cout = 1'b0;
      do_op(8'hAA, 8'h55, 1'b0, "post_abort");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
